// File: rtl/grammer_frame_collector.sv
// grammer_frame_collector: groups result words into frames, computes sum/max, queues frames in a small FIFO
module grammer_frame_collector #(
  parameter int WIDTH = 32,
  parameter int FRAME_LEN = 4,
  parameter int DEPTH = 2,
  parameter int IDX_W = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               abort,
  output logic                               frame_valid,
  input  logic                               frame_ready,
  output logic [WIDTH+$clog2(FRAME_LEN)-1:0] frame_sum,
  output logic [WIDTH-1:0]                   frame_max,
  output logic [IDX_W-1:0]                   frame_idx,
  output logic [IDX_W-1:0]                   drop_cnt,
  output logic                               busy
);
  localparam int LW = $clog2(FRAME_LEN);
  localparam int SW = WIDTH + LW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = SW + WIDTH + IDX_W;
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_n;
  logic [LW-1:0] word_cnt, cnt_n;
  logic [SW-1:0] sum_acc, sum_n, word_sum;
  logic [WIDTH-1:0] max_acc, max_n, word_max;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [IDX_W-1:0] next_idx;
  logic done, pop, full, wr, drop;
  assign word_sum = (state == IDLE) ? {{LW{1'b0}}, in_data} : sum_acc + {{LW{1'b0}}, in_data};
  assign word_max = (state == IDLE || in_data > max_acc) ? in_data : max_acc;
  assign done = in_valid && !abort && state == COLLECT && word_cnt == LW'(FRAME_LEN - 1);
  assign pop = frame_valid && frame_ready;
  assign full = count == CW'(DEPTH);
  assign wr = done && (!full || pop);
  assign drop = done && full && !pop;
  assign frame_valid = count != '0;
  assign busy = state == COLLECT || count != '0;
  assign {frame_sum, frame_max, frame_idx} = mem[rd_ptr];
  // collector state and accumulator registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      word_cnt <= '0;
      sum_acc <= '0;
      max_acc <= '0;
    end else begin
      state <= state_n;
      word_cnt <= cnt_n;
      sum_acc <= sum_n;
      max_acc <= max_n;
    end
  end
  // next collector state: abort wins over any word, completion clears the accumulators
  always_comb begin
    state_n = state;
    cnt_n = word_cnt;
    sum_n = sum_acc;
    max_n = max_acc;
    if (abort) begin
      state_n = IDLE;
      cnt_n = '0;
      sum_n = '0;
      max_n = '0;
    end else if (in_valid) begin
      state_n = done ? IDLE : COLLECT;
      cnt_n = done ? '0 : word_cnt + 1'b1;
      sum_n = done ? '0 : word_sum;
      max_n = done ? '0 : word_max;
    end
  end
  // output FIFO, frame index and saturating drop counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      next_idx <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr) mem[wr_ptr] <= {word_sum, word_max, next_idx};
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
      next_idx <= next_idx + IDX_W'(done);
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_grammer_frame_collector.sv
// tb_grammer_frame_collector: directed and random stimulus against a queue-based frame model
module tb_grammer_frame_collector;
  localparam int FL = 4;
  localparam int D = 2;
  logic clk = 0;
  logic reset = 0;
  logic in_valid = 0;
  logic [31:0] in_data = 0;
  logic abort = 0;
  logic frame_ready = 0;
  logic frame_valid;
  logic [33:0] frame_sum;
  logic [31:0] frame_max;
  logic [7:0] frame_idx;
  logic [7:0] drop_cnt;
  logic busy;
  int vectors = 0;
  int errs = 0;
  typedef struct {
    logic [33:0] s;
    logic [31:0] m;
    logic [7:0] i;
  } fr_t;
  logic [31:0] words[$];
  fr_t fq[$];
  logic [7:0] m_idx = 0;
  logic [7:0] m_drop = 0;

  grammer_frame_collector dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .abort(abort),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_sum(frame_sum),
    .frame_max(frame_max), .frame_idx(frame_idx), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    check("frame_valid", 64'(frame_valid), 64'(fq.size() != 0));
    check("busy", 64'(busy), 64'(words.size() != 0 || fq.size() != 0));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (fq.size() != 0) begin
      check("frame_sum", 64'(frame_sum), 64'(fq[0].s));
      check("frame_max", 64'(frame_max), 64'(fq[0].m));
      check("frame_idx", 64'(frame_idx), 64'(fq[0].i));
    end
  endtask

  task automatic model_clear();
    words.delete();
    fq.delete();
    m_idx = 0;
    m_drop = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic ab, input logic rdy);
    fr_t nf;
    int n;
    logic pop, done;
    in_valid = v;
    in_data = d;
    abort = ab;
    frame_ready = rdy;
    n = fq.size();
    pop = n > 0 && rdy;
    done = 0;
    nf.s = 0;
    nf.m = 0;
    nf.i = 0;
    if (ab) words.delete();
    else if (v) begin
      words.push_back(d);
      if (words.size() == FL) begin
        foreach (words[k]) begin
          nf.s += 34'(words[k]);
          if (words[k] > nf.m) nf.m = words[k];
        end
        nf.i = m_idx;
        m_idx++;
        words.delete();
        done = 1;
      end
    end
    if (pop) void'(fq.pop_front());
    if (done) begin
      if (n < D || pop) fq.push_back(nf);
      else if (m_drop != 8'hff) m_drop++;
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic frame4(input logic [31:0] a, b, c, e, input logic rdy);
    step(1, a, 0, rdy);
    step(1, b, 0, rdy);
    step(1, c, 0, rdy);
    step(1, e, 0, rdy);
  endtask

  task automatic do_reset();
    in_valid = 0;
    abort = 0;
    frame_ready = 0;
    reset = 0;
    #1;
    model_clear();
    compare();
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    compare();
    check("reset_sum", 64'(frame_sum), 64'd0);
    reset = 1;
    frame4(1, 2, 3, 4, 1);
    check("plan_sum10", 64'(frame_sum), 64'd10);
    check("plan_max4", 64'(frame_max), 64'd4);
    step(0, 0, 0, 1);
    check("plan_empty_busy", 64'(busy), 64'd0);
    frame4(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 0);
    check("plan_sum_max", 64'(frame_sum), 64'h3fffffffc);
    check("plan_max_ff", 64'(frame_max), 64'hffffffff);
    step(0, 0, 0, 1);
    do_reset();
    for (int f = 0; f < 3; f++) frame4(32'(f + 10), 32'(f + 20), 32'(f + 5), 32'(f + 1), 0);
    check("plan_drop1", 64'(drop_cnt), 64'd1);
    check("plan_head0", 64'(frame_idx), 64'd0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    frame4(7, 8, 9, 10, 0);
    check("plan_idx3", 64'(frame_idx), 64'd3);
    frame4(11, 12, 13, 14, 0);
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    step(1, 4, 0, 1);
    check("plan_push_pop_drop", 64'(drop_cnt), 64'd1);
    check("plan_push_pop_head", 64'(frame_idx), 64'd4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 5, 0, 0);
    step(1, 6, 0, 0);
    step(1, 7, 0, 0);
    step(1, 8, 1, 0);
    check("plan_abort_novalid", 64'(frame_valid), 64'd0);
    frame4(1, 1, 1, 1, 0);
    check("plan_sum4", 64'(frame_sum), 64'd4);
    step(1, 9, 0, 0);
    step(1, 9, 0, 0);
    #2;
    reset = 0;
    #1;
    model_clear();
    check("async_valid", 64'(frame_valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_drop", 64'(drop_cnt), 64'd0);
    in_valid = 0;
    @(posedge clk);
    #1;
    reset = 1;
    frame4(2, 4, 6, 8, 0);
    check("plan_idx0_after_reset", 64'(frame_idx), 64'd0);
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 9) < 7, ($urandom_range(0, 7) == 0) ? 32'hffffffff : $urandom,
           $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/grammer_frame_collector.md
Name: grammer_frame_collector

Overview:
Downstream consumer of the grammerTest result stream. It gathers consecutive 32-bit result words into fixed-length frames and computes a per-frame sum and maximum. Completed frames go into a small output FIFO with a valid/ready handshake. Frames that complete while the FIFO is full are dropped and counted.

Parameters:
WIDTH, 32, data word width
FRAME_LEN, 4, words per frame; power of two, at least 2
DEPTH, 2, output FIFO entries; power of two, at least 2
IDX_W, 8, width of frame index and drop counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  in_data carries a word this cycle; no backpressure toward upstream
in_data  input  WIDTH  result word from upstream stage
abort  input  1  discard the partial frame
frame_valid  output  1  FIFO head is valid
frame_ready  input  1  consumer accepts the head
frame_sum  output  WIDTH+log2(FRAME_LEN)  sum of frame words, zero-extended, no wrap
frame_max  output  WIDTH  unsigned maximum word of the frame
frame_idx  output  IDX_W  sequence number of the head frame
drop_cnt  output  IDX_W  count of dropped frames, saturating
busy  output  1  partial frame in progress, or FIFO not empty

Behaviour:
- Reset (reset=0, async):
  - All outputs and state go to 0: FIFO empty, word counter 0, accumulators 0, next-index counter 0, drop_cnt 0.
  - Reset asserted mid-frame or with the FIFO non-empty discards everything.
- FSM states:
  - IDLE: word_cnt=0. An accepted word loads sum_acc=data and max_acc=data, then moves to COLLECT with word_cnt=1.
  - COLLECT: each accepted word does sum_acc += data, max_acc = max(max_acc, data), word_cnt++.
  - Frame completes when a word is accepted with word_cnt=FRAME_LEN-1. The frame result includes that word. The FSM returns to IDLE with word_cnt=0.
  - No words are consumed while in_valid=0; the FSM holds its state, with no timeout.
- abort:
  - In COLLECT, abort clears word_cnt and the accumulators and returns to IDLE. Any word presented in the same cycle is discarded, even if it is the completing word.
  - In IDLE, abort with in_valid=1 also discards the word.
  - abort never touches the FIFO, frame_idx or drop_cnt.
- Push:
  - A completed frame writes {sum, max, next_idx} into the FIFO at the same clock edge as the completing word.
  - frame_valid is therefore visible 1 cycle after the last word's accept cycle.
  - next_idx increments on every completed frame, including dropped ones, wrapping modulo 2^IDX_W. The consumer sees gaps when frames are dropped.
- Pop: occurs when frame_valid=1 and frame_ready=1. frame_ready while empty has no effect.
- Outputs frame_sum, frame_max and frame_idx come directly from the FIFO head register. They hold stable while frame_valid=1 and frame_ready=0.
- Full FIFO:
  - Push with no pop in the same cycle: the frame is dropped, FIFO contents are unchanged, and drop_cnt++ (holds at 2^IDX_W-1).
  - Push with a simultaneous pop: both take effect and nothing is dropped.
- Empty FIFO: push plus frame_ready in the same cycle does not bypass; the new frame becomes the head next cycle.
- Widths: sum is zero-extended to WIDTH+log2(FRAME_LEN) bits; the maximum value (all words 0xFFFFFFFF) gives 0x3_FFFF_FFFC without overflow. The max comparison is unsigned.
- busy = (state==COLLECT) || (FIFO count != 0).

Test Plan:
- Reset then words 1,2,3,4 on consecutive cycles, frame_ready=1 -> one cycle after word 4, frame_valid=1, frame_sum=10, frame_max=4, frame_idx=0; popped, then frame_valid=0, busy=0.
- Four words of 0xFFFFFFFF -> frame_sum=0x3FFFFFFFC, frame_max=0xFFFFFFFF.
- frame_ready=0, three full frames sent -> FIFO holds idx 0 and 1, drop_cnt=1; after draining, the next frame carries idx 3.
- FIFO full, last word of a new frame arrives with frame_ready=1 -> old head popped, new frame pushed, drop_cnt unchanged.
- Words 5,6,7 then abort together with word 8 -> no frame produced; the following words 1,1,1,1 give frame_sum=4.
- reset deasserted-then-asserted (driven low) asynchronously mid-frame with FIFO count 1 -> frame_valid=0, busy=0, drop_cnt=0 immediately; the next frame gets idx 0.
